// File: rtl/sw_gpio_pkg.sv
// Shared definitions for the GPIO result transmitter: output FSM encoding,
// FIFO entry layout and the user GPIO bit positions the outputs map onto.
package sw_gpio_pkg;

    localparam int DATA_W          = 8;
    localparam int ENTRY_W         = 9;   // {last, data}
    localparam int GPIO_DATA_LSB   = 0;
    localparam int GPIO_DATA_MSB   = 7;
    localparam int GPIO_STROBE_BIT = 8;
    localparam int GPIO_BUSY_BIT   = 20;
    // data byte + strobe + busy, all permanently driven
    localparam int OEB_W           = (GPIO_DATA_MSB - GPIO_DATA_LSB + 1) + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } gpio_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sw_gpio_tx_if.sv
// Result-byte stream from the accelerator into the GPIO transmitter.
// Handshake: a byte (res_data, res_last) transfers on a rising clock edge
// where res_valid && res_ready are both high. res_ready depends only on
// registered FIFO state, never on res_valid; res_last is only meaningful
// while res_valid is high.
interface sw_gpio_tx_if;
    import sw_gpio_pkg::*;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              res_ready;

    modport master (output res_valid, res_data, res_last, input res_ready);
    modport slave  (input res_valid, res_data, res_last, output res_ready);

endinterface

// File: rtl/sw_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Read data is the head entry,
// available combinationally whenever the FIFO is not empty.
module sw_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sw_gpio_tx.sv
// Streams accelerator result bytes out on user GPIO: io_data carries the
// byte, io_strobe pulses for STB_CYCLES with GAP_CYCLES of quiet after it,
// io_busy spans a job from start until the last byte's strobe ends, and
// cyc_count measures how long io_busy was high.
module sw_gpio_tx
    import sw_gpio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int STB_CYCLES = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    sw_gpio_tx_if.slave       res,
    output logic [DATA_W-1:0] io_data,
    output logic              io_strobe,
    output logic              io_busy,
    output logic [OEB_W-1:0]  io_oeb,
    output logic [31:0]       cyc_count,
    output gpio_state_t       state_dbg
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    gpio_state_t          state;
    logic [CNT_W-1:0]     phase_cnt;
    logic                 last_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 strobe_done;
    fifo_entry_t          wr_entry;
    fifo_entry_t          rd_entry;
    logic [ENTRY_W-1:0]   rd_raw;

    assign res.res_ready = !fifo_full;
    assign push          = res.res_valid && !fifo_full;
    assign wr_entry      = '{last: res.res_last, data: res.res_data};
    assign rd_entry      = fifo_entry_t'(rd_raw);
    assign strobe_done   = (state == ST_STROBE) && (phase_cnt == '0);
    assign io_oeb        = '0;
    assign state_dbg     = state;

    sw_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_raw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pop whenever the FSM is about to be idle and a byte is waiting, so a
    // full gap (or none) separates strobes without an extra idle cycle.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            ST_IDLE:   pop = !fifo_empty;
            ST_STROBE: pop = !fifo_empty && (phase_cnt == '0) && (GAP_CYCLES == 0);
            ST_GAP:    pop = !fifo_empty && (phase_cnt == '0);
            default:   pop = 1'b0;
        endcase
    end

    // Output FSM, job-busy flag and busy-cycle counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            io_data   <= '0;
            io_strobe <= 1'b0;
            last_q    <= 1'b0;
            io_busy   <= 1'b0;
            cyc_count <= '0;
        end else begin
            // start only opens a job when none is running
            if (start && !io_busy) begin
                io_busy   <= 1'b1;
                cyc_count <= '0;
            end else if (io_busy) begin
                if (cyc_count != 32'hFFFF_FFFF) cyc_count <= cyc_count + 32'd1;
                if (strobe_done && last_q) io_busy <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_STROBE: begin
                    if (phase_cnt == '0) begin
                        io_strobe <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_GAP;
                            phase_cnt <= GAP_LOAD;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == '0) state <= ST_IDLE;
                    else                 phase_cnt <= phase_cnt - 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    io_strobe <= 1'b0;
                end
            endcase

            // loading the next byte overrides whatever the phase logic chose
            if (pop) begin
                io_data   <= rd_entry.data;
                last_q    <= rd_entry.last;
                io_strobe <= 1'b1;
                phase_cnt <= STB_LOAD;
                state     <= ST_STROBE;
            end
        end
    end

endmodule

// File: tb/tb_sw_gpio_tx.sv
// Directed bench for sw_gpio_tx: a default build (STB=2, GAP=2, depth 8)
// and a back-to-back build (STB=1, GAP=0) sharing clock and reset.
module tb_sw_gpio_tx;
    import sw_gpio_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetb;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic        start;
    logic [7:0]  io_data;
    logic        io_strobe;
    logic        io_busy;
    logic [9:0]  io_oeb;
    logic [31:0] cyc_count;
    gpio_state_t state_dbg;

    logic        fast_start;
    logic [7:0]  fast_io_data;
    logic        fast_io_strobe;
    logic        fast_io_busy;
    logic [9:0]  fast_io_oeb;
    logic [31:0] fast_cyc_count;
    gpio_state_t fast_state_dbg;

    sw_gpio_tx_if bus ();
    sw_gpio_tx_if fast_bus ();

    sw_gpio_tx #(.FIFO_DEPTH(8), .STB_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .start     (start),
        .res       (bus),
        .io_data   (io_data),
        .io_strobe (io_strobe),
        .io_busy   (io_busy),
        .io_oeb    (io_oeb),
        .cyc_count (cyc_count),
        .state_dbg (state_dbg)
    );

    sw_gpio_tx #(.FIFO_DEPTH(8), .STB_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
        .clock     (clock),
        .resetb    (resetb),
        .start     (fast_start),
        .res       (fast_bus),
        .io_data   (fast_io_data),
        .io_strobe (fast_io_strobe),
        .io_busy   (fast_io_busy),
        .io_oeb    (fast_io_oeb),
        .cyc_count (fast_cyc_count),
        .state_dbg (fast_state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_res(input logic v, input logic [7:0] d, input logic l);
        bus.res_valid = v;
        bus.res_data  = d;
        bus.res_last  = l;
    endtask

    task automatic drive_fast(input logic v, input logic [7:0] d, input logic l);
        fast_bus.res_valid = v;
        fast_bus.res_data  = d;
        fast_bus.res_last  = l;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   accepted, emitted, hi_len, lo_len, budget, rises;
        logic prev_stb, ready_dropped, xfer;

        resetb     = 1'b0;
        start      = 1'b0;
        fast_start = 1'b0;
        drive_res(1'b0, 8'h00, 1'b0);
        drive_fast(1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clock);
        #1;

        // reset state
        check("rst_io_data",   32'(io_data), 32'h0);
        check("rst_io_strobe", 32'(io_strobe), 32'h0);
        check("rst_io_busy",   32'(io_busy), 32'h0);
        check("rst_cyc_count", cyc_count, 32'h0);
        check("rst_io_oeb",    32'(io_oeb), 32'h0);
        check("rst_state",     32'(state_dbg), 32'(ST_IDLE));
        resetb = 1'b1;
        tick();
        check("rst_res_ready", 32'(bus.res_ready), 32'h1);

        // single byte A5 with last
        start = 1'b1; tick(); start = 1'b0;
        check("single_busy_set", 32'(io_busy), 32'h1);
        check("single_cyc_zero", cyc_count, 32'h0);
        drive_res(1'b1, 8'hA5, 1'b1); tick(); drive_res(1'b0, 8'h00, 1'b0);
        check("single_no_early_strobe", 32'(io_strobe), 32'h0);
        tick();
        check("single_strobe_1", 32'(io_strobe), 32'h1);
        check("single_data", 32'(io_data), 32'hA5);
        tick();
        check("single_strobe_2", 32'(io_strobe), 32'h1);
        check("single_busy_during", 32'(io_busy), 32'h1);
        tick();
        check("single_strobe_end", 32'(io_strobe), 32'h0);
        check("single_busy_clear", 32'(io_busy), 32'h0);
        check("single_cyc_count", cyc_count, 32'd4);
        tick();
        check("single_cyc_hold", cyc_count, 32'd4);
        check("single_data_hold", 32'(io_data), 32'hA5);
        idle(6);

        // second start while busy is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("restart_cyc_zero", cyc_count, 32'h0);
        idle(2);
        check("restart_cyc_2", cyc_count, 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_ignored_cyc", cyc_count, 32'd3);
        check("restart_ignored_busy", 32'(io_busy), 32'h1);
        drive_res(1'b1, 8'h11, 1'b1); tick(); drive_res(1'b0, 8'h00, 1'b0);
        tick();
        check("restart_data", 32'(io_data), 32'h11);
        check("restart_cyc_5", cyc_count, 32'd5);
        idle(2);
        check("restart_busy_clear", 32'(io_busy), 32'h0);
        check("restart_cyc_final", cyc_count, 32'd7);
        idle(6);

        // byte outside a job is still emitted
        drive_res(1'b1, 8'h77, 1'b0); tick(); drive_res(1'b0, 8'h00, 1'b0);
        tick();
        check("nojob_strobe", 32'(io_strobe), 32'h1);
        check("nojob_data", 32'(io_data), 32'h77);
        check("nojob_busy", 32'(io_busy), 32'h0);
        check("nojob_cyc_hold", cyc_count, 32'd7);
        idle(6);

        // start together with a last byte into an empty FIFO
        start = 1'b1; drive_res(1'b1, 8'h5A, 1'b1); tick();
        start = 1'b0; drive_res(1'b0, 8'h00, 1'b0);
        check("startlast_busy", 32'(io_busy), 32'h1);
        check("startlast_cyc", cyc_count, 32'h0);
        tick();
        check("startlast_strobe", 32'(io_strobe), 32'h1);
        check("startlast_data", 32'(io_data), 32'h5A);
        idle(2);
        check("startlast_busy_clear", 32'(io_busy), 32'h0);
        check("startlast_cyc", cyc_count, 32'd3);
        idle(6);

        // burst of 64 bytes with res_valid held high
        accepted = 0; emitted = 0; hi_len = 0; lo_len = 0; budget = 0;
        prev_stb = 1'b0; ready_dropped = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        while ((emitted < 64 || io_strobe || prev_stb) && budget < 400) begin
            if (io_strobe && !prev_stb) begin
                check("burst_data", 32'(io_data), 32'(emitted));
                emitted++;
                if (emitted > 1) check("burst_gap_len", 32'(lo_len), 32'd2);
                hi_len = 1;
            end else if (io_strobe) begin
                hi_len++;
            end
            if (!io_strobe && prev_stb) begin
                check("burst_strobe_len", 32'(hi_len), 32'd2);
                lo_len = 1;
            end else if (!io_strobe) begin
                lo_len++;
            end
            check("burst_full_flag", 32'(bus.res_ready), 32'((accepted - emitted) != 8));
            if (!bus.res_ready && !ready_dropped) begin
                ready_dropped = 1'b1;
                check("burst_ready_drop_level", 32'(accepted - emitted), 32'd8);
            end
            drive_res(accepted < 64, 8'(accepted), accepted == 63);
            xfer     = bus.res_valid && bus.res_ready;
            prev_stb = io_strobe;
            tick();
            if (xfer) accepted++;
            budget++;
        end
        drive_res(1'b0, 8'h00, 1'b0);
        check("burst_accepted", 32'(accepted), 32'd64);
        check("burst_emitted", 32'(emitted), 32'd64);
        check("burst_ready_dropped", 32'(ready_dropped), 32'h1);
        check("burst_busy_clear", 32'(io_busy), 32'h0);
        idle(6);

        // reset in the middle of a strobe, with a byte still queued
        start = 1'b1; drive_res(1'b1, 8'h99, 1'b0); tick();
        start = 1'b0; drive_res(1'b1, 8'h42, 1'b0); tick();
        drive_res(1'b0, 8'h00, 1'b0);
        check("midrst_strobe_before", 32'(io_strobe), 32'h1);
        check("midrst_data_before", 32'(io_data), 32'h99);
        #2 resetb = 1'b0;
        #1;
        check("midrst_strobe", 32'(io_strobe), 32'h0);
        check("midrst_busy", 32'(io_busy), 32'h0);
        check("midrst_cyc", cyc_count, 32'h0);
        check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        resetb = 1'b1;
        tick();
        start = 1'b1; drive_res(1'b1, 8'h3C, 1'b1); tick();
        start = 1'b0; drive_res(1'b0, 8'h00, 1'b0);
        rises = 0; prev_stb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (io_strobe && !prev_stb) begin
                rises++;
                if (rises == 1) check("postrst_data", 32'(io_data), 32'h3C);
            end
            prev_stb = io_strobe;
            tick();
        end
        check("postrst_one_byte", 32'(rises), 32'd1);
        check("postrst_busy", 32'(io_busy), 32'h0);
        check("postrst_cyc", cyc_count, 32'd3);

        // back-to-back build: 8 bytes, one strobe cycle each, no gaps
        for (int i = 0; i < 8; i++) begin
            fast_start = (i == 0);
            drive_fast(1'b1, 8'(8'h10 + i), i == 7);
            tick();
            if (i >= 1) begin
                check("fast_strobe", 32'(fast_io_strobe), 32'h1);
                check("fast_data", 32'(fast_io_data), 32'(8'h10 + i - 1));
            end
        end
        fast_start = 1'b0;
        drive_fast(1'b0, 8'h00, 1'b0);
        tick();
        check("fast_strobe_last", 32'(fast_io_strobe), 32'h1);
        check("fast_data_last", 32'(fast_io_data), 32'h17);
        tick();
        check("fast_strobe_end", 32'(fast_io_strobe), 32'h0);
        check("fast_busy_clear", 32'(fast_io_busy), 32'h0);
        check("fast_cyc", fast_cyc_count, 32'd9);
        check("fast_oeb", 32'(fast_io_oeb), 32'h0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_gpio_tx.md
SW_GPIO_TX -- requirements
Module: sw_gpio_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, result-byte buffer depth (power of two, >=2).
REQ-002 SHALL have parameter STB_CYCLES, default 2, cycles io_strobe stays high per byte (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles after each strobe before the next byte (>=0).
REQ-004 clock  input  1  single clock; all state on its rising edge.
REQ-005 resetb  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse marking the start of an 8x8 job.
REQ-007 res_valid  input  1  accelerator result byte valid.
REQ-008 res_data  input  8  accelerator result byte.
REQ-009 res_last  input  1  marks the final byte of the job, qualified by res_valid.
REQ-010 res_ready  output  1  high when the FIFO can accept a byte.
REQ-011 io_data  output  8  byte driven onto user GPIO[7:0].
REQ-012 io_strobe  output  1  byte-valid strobe on user GPIO[8].
REQ-013 io_busy  output  1  job-active flag on user GPIO[20].
REQ-014 io_oeb  output  10  output-enable bars for data, strobe and busy; constant 0.
REQ-015 cyc_count  output  32  cycles io_busy has been high for the current or last job.

Function
REQ-016 Input handshake: a byte transfers when res_valid && res_ready on a rising edge; res_ready = !fifo_full.
REQ-017 FIFO entry SHALL be {last, data}, 9 bits; pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap bit; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when full (pop frees the slot; res_ready still follows the registered full flag).
REQ-019 Output FSM states: IDLE, STROBE, GAP.
REQ-020 IDLE: if FIFO not empty, pop, register io_data <= data and last_q <= last, assert io_strobe, go to STROBE; otherwise stay.
REQ-021 STROBE: hold io_data and io_strobe=1 for exactly STB_CYCLES cycles, then deassert io_strobe and go to GAP (or IDLE if GAP_CYCLES=0).
REQ-022 GAP: io_strobe=0, io_data held, for GAP_CYCLES cycles, then go to IDLE.
REQ-023 First byte appears on io_data with io_strobe high in the second cycle after its input handshake (latency 2 from an empty FIFO in IDLE).
REQ-024 io_busy SHALL set on the cycle after start and clear on the cycle after the STROBE phase of a byte with last_q=1 ends.
REQ-025 start while io_busy=1 SHALL be ignored; bytes arriving while io_busy=0 SHALL still be accepted and emitted.
REQ-026 cyc_count SHALL clear to 0 on the cycle io_busy rises, increment by 1 each cycle io_busy is high, hold when io_busy is low, and saturate at 32'hFFFF_FFFF.
REQ-027 res_last with an empty FIFO and simultaneous start SHALL set busy first and clear it after that byte's strobe.

Reset
REQ-028 On resetb low, asynchronously: FSM=IDLE, pointers=0, io_data=0, io_strobe=0, io_busy=0, last_q=0, cyc_count=0, res_ready=1 after release.
REQ-029 Reset mid-strobe SHALL drop io_strobe immediately and discard FIFO contents.

Structure
REQ-030 FSM state encoding, FIFO entry width (9) and the GPIO bit indices 0-7, 8, 20 SHALL live in a shared package sw_gpio_pkg.
REQ-031 The FIFO SHALL be a sub-module sw_sync_fifo (parameterized width/depth); FSM, busy flag and counter stay in sw_gpio_tx.

Verification
REQ-032 Single byte: start, then 8'hA5 with last -> io_data=A5, io_strobe high 2 cycles, io_busy clears one cycle after strobe ends, cyc_count equals busy-high cycles.
REQ-033 Burst of 64 bytes (0..63, last on 63) with res_valid held high -> res_ready drops at 8 buffered, all 64 emitted in order, each strobe exactly 2 cycles with 2-cycle gaps.
REQ-034 Full FIFO with simultaneous push and pop -> no byte lost or duplicated, full flag correct the next cycle.
REQ-035 Second start while busy -> ignored; cyc_count not cleared.
REQ-036 resetb low during STROBE -> io_strobe=0, io_busy=0, cyc_count=0 the same cycle; next job of byte 8'h3C emits only 3C.
REQ-037 STB_CYCLES=1, GAP_CYCLES=0 build: 8 bytes emitted in 8 consecutive strobe cycles after the first.
